alu_rr_scheduler: RTL and testbench

Shares one combinational 32-bit ALU between NUM_REQ requesters, e.g. the core's execute stage and a debug/DMA port.
- Arbitrates round-robin, registers the winner's operands and drives them to the ALU.
- Captures the ALU result and flags, then returns them with a requester ID over a valid/ready response channel.
- Sits between the requesters and the ALU instance; the ALU stays purely combinational.

---
 rtl/alu_sched_pkg.sv | 27 ++
 rtl/rr_arbiter.sv | 33 +++
 rtl/alu_rr_scheduler.sv | 159 +++++++++++++++
 tb/tb_alu_rr_scheduler.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_sched_pkg.sv
// Shared types and constants for the round-robin ALU scheduler.
// Holds the FSM state encoding, the ALU op codes and the flag bit positions.
package alu_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } state_t;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_SLT = 3'b101;

  localparam int FLG_N = 3;
  localparam int FLG_Z = 2;
  localparam int FLG_C = 1;
  localparam int FLG_V = 0;

  // The code is zero-extended by the caller so one helper serves any control width.
  function automatic logic isLegalOp(input logic [31:0] code);
    return code inside {32'(OP_ADD), 32'(OP_SUB), 32'(OP_AND), 32'(OP_OR), 32'(OP_SLT)};
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches upward from the requester after the last grant.
// Produces a one-hot grant and its index; all zero when disabled or nobody requests.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  localparam int IDX_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_lastGrant,
  input  logic               i_en,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDX_W-1:0]   o_grantIdx
);

  logic             w_found;
  logic [IDX_W-1:0] w_cand;

  always_comb begin
    o_grant    = '0;
    o_grantIdx = '0;
    w_found    = 1'b0;
    w_cand     = '0;
    // Offset NUM_REQ wraps back to the last winner, so it is checked last.
    for (int off = 1; off <= NUM_REQ; off++) begin
      w_cand = IDX_W'((int'(i_lastGrant) + off) % NUM_REQ);
      if (i_en && !w_found && i_req[w_cand]) begin
        w_found         = 1'b1;
        o_grant[w_cand] = 1'b1;
        o_grantIdx      = w_cand;
      end
    end
  end

endmodule

// File: rtl/alu_rr_scheduler.sv
// Shares one combinational ALU between NUM_REQ requesters with round-robin grants.
// Optional macro ALU_OPCHK_EN: illegal control codes are answered locally with rsp_err=1.
module alu_rr_scheduler
  import alu_sched_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 32,
  parameter int CTRL_W  = 3,
  localparam int ID_W   = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  input  logic [NUM_REQ*CTRL_W-1:0] req_ctrl,
  output logic [DATA_W-1:0]         alu_a,
  output logic [DATA_W-1:0]         alu_b,
  output logic [CTRL_W-1:0]         alu_ctrl,
  input  logic [DATA_W-1:0]         alu_result,
  input  logic [3:0]                alu_flags,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [ID_W-1:0]           rsp_id,
  output logic [DATA_W-1:0]         rsp_result,
  output logic [3:0]                rsp_flags,
  output logic                      rsp_err
);

  state_t              r_state;
  state_t              w_nextState;
  logic [ID_W-1:0]     r_lastGrant;
  logic [DATA_W-1:0]   r_aluA;
  logic [DATA_W-1:0]   r_aluB;
  logic [CTRL_W-1:0]   r_aluCtrl;
  logic [ID_W-1:0]     r_rspId;
  logic [DATA_W-1:0]   r_rspResult;
  logic [3:0]          r_rspFlags;

  logic                w_arbEn;
  logic [NUM_REQ-1:0]  w_grant;
  logic [ID_W-1:0]     w_grantIdx;
  logic                w_take;
  logic [DATA_W-1:0]   w_selA;
  logic [DATA_W-1:0]   w_selB;
  logic [CTRL_W-1:0]   w_selCtrl;

  // Gating with rst keeps req_ready low while reset is held, not just after it.
  assign w_arbEn = (r_state == IDLE) && !rst;
  assign w_take  = |w_grant;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_arbiter (
    .i_req      (req_valid),
    .i_lastGrant(r_lastGrant),
    .i_en       (w_arbEn),
    .o_grant    (w_grant),
    .o_grantIdx (w_grantIdx)
  );

  always_comb begin
    w_selA    = '0;
    w_selB    = '0;
    w_selCtrl = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_selA    = req_a[i*DATA_W +: DATA_W];
        w_selB    = req_b[i*DATA_W +: DATA_W];
        w_selCtrl = req_ctrl[i*CTRL_W +: CTRL_W];
      end
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_take) w_nextState = ISSUE;
      ISSUE:   w_nextState = RESP;
      RESP:    if (rsp_ready) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

`ifdef ALU_OPCHK_EN
  logic r_illegal;
  logic r_rspErr;
  logic w_selLegal;

  assign w_selLegal = isLegalOp(32'(w_selCtrl));
  assign rsp_err    = r_rspErr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_illegal <= 1'b0;
      r_rspErr  <= 1'b0;
    end else begin
      if (w_take) r_illegal <= !w_selLegal;
      if (r_state == ISSUE) r_rspErr <= r_illegal;
    end
  end
`else
  logic w_selLegal;

  assign w_selLegal = 1'b1;
  assign rsp_err    = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_lastGrant <= ID_W'(NUM_REQ - 1);
      r_aluA      <= '0;
      r_aluB      <= '0;
      r_aluCtrl   <= '0;
      r_rspId     <= '0;
      r_rspResult <= '0;
      r_rspFlags  <= '0;
    end else begin
      r_state <= w_nextState;
      if (w_take) begin
        r_rspId     <= w_grantIdx;
        r_lastGrant <= w_grantIdx;
        // Illegal codes never reach the ALU, so its inputs keep the last legal op.
        if (w_selLegal) begin
          r_aluA    <= w_selA;
          r_aluB    <= w_selB;
          r_aluCtrl <= w_selCtrl;
        end
      end
      if (r_state == ISSUE) begin
`ifdef ALU_OPCHK_EN
        if (r_illegal) begin
          r_rspResult        <= '0;
          r_rspFlags         <= '0;
          r_rspFlags[FLG_Z]  <= 1'b1;
        end else begin
          r_rspResult <= alu_result;
          r_rspFlags  <= alu_flags;
        end
`else
        r_rspResult <= alu_result;
        r_rspFlags  <= alu_flags;
`endif
      end
    end
  end

  assign req_ready  = w_grant;
  assign alu_a      = r_aluA;
  assign alu_b      = r_aluB;
  assign alu_ctrl   = r_aluCtrl;
  assign rsp_valid  = (r_state == RESP);
  assign rsp_id     = r_rspId;
  assign rsp_result = r_rspResult;
  assign rsp_flags  = r_rspFlags;

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Directed self-checking bench for alu_rr_scheduler with a behavioural 32-bit ALU.
// Build with +define+ALU_OPCHK_EN to check the illegal-op handling instead of pass-through.
module tb_alu_rr_scheduler;
  import alu_sched_pkg::*;

  localparam int NUM_REQ = 2;
  localparam int DATA_W  = 32;
  localparam int CTRL_W  = 3;

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic [NUM_REQ-1:0]        reqValid = '0;
  logic [NUM_REQ-1:0]        reqReady;
  logic [NUM_REQ*DATA_W-1:0] reqA = '0;
  logic [NUM_REQ*DATA_W-1:0] reqB = '0;
  logic [NUM_REQ*CTRL_W-1:0] reqCtrl = '0;
  logic [DATA_W-1:0]         aluA;
  logic [DATA_W-1:0]         aluB;
  logic [CTRL_W-1:0]         aluCtrl;
  logic [DATA_W-1:0]         aluResult;
  logic [3:0]                aluFlags;
  logic                      rspValid;
  logic                      rspReady = 1'b0;
  logic [0:0]                rspId;
  logic [DATA_W-1:0]         rspResult;
  logic [3:0]                rspFlags;
  logic                      rspErr;

  int checks = 0;
  int errors = 0;

  alu_rr_scheduler #(
    .NUM_REQ(NUM_REQ),
    .DATA_W (DATA_W),
    .CTRL_W (CTRL_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (reqValid),
    .req_ready (reqReady),
    .req_a     (reqA),
    .req_b     (reqB),
    .req_ctrl  (reqCtrl),
    .alu_a     (aluA),
    .alu_b     (aluB),
    .alu_ctrl  (aluCtrl),
    .alu_result(aluResult),
    .alu_flags (aluFlags),
    .rsp_valid (rspValid),
    .rsp_ready (rspReady),
    .rsp_id    (rspId),
    .rsp_result(rspResult),
    .rsp_flags (rspFlags),
    .rsp_err   (rspErr)
  );

  always #5 clk = ~clk;

  // Reference ALU: C on SUB means "no borrow", SLT is a signed compare.
  logic [32:0] aluSum;
  always_comb begin
    aluSum    = '0;
    aluResult = '0;
    aluFlags  = '0;
    case (aluCtrl)
      OP_ADD: begin
        aluSum          = {1'b0, aluA} + {1'b0, aluB};
        aluResult       = aluSum[31:0];
        aluFlags[FLG_C] = aluSum[32];
        aluFlags[FLG_V] = (aluA[31] == aluB[31]) && (aluResult[31] != aluA[31]);
      end
      OP_SUB: begin
        aluSum          = {1'b0, aluA} + {1'b0, ~aluB} + 33'd1;
        aluResult       = aluSum[31:0];
        aluFlags[FLG_C] = aluSum[32];
        aluFlags[FLG_V] = (aluA[31] != aluB[31]) && (aluResult[31] != aluA[31]);
      end
      OP_AND:  aluResult = aluA & aluB;
      OP_OR:   aluResult = aluA | aluB;
      OP_SLT:  aluResult = ($signed(aluA) < $signed(aluB)) ? 32'd1 : 32'd0;
      default: aluResult = '0;
    endcase
    aluFlags[FLG_N] = aluResult[31];
    aluFlags[FLG_Z] = (aluResult == 32'd0);
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int r, input logic [31:0] a, input logic [31:0] b, input logic [2:0] ctrl);
    reqA[r*DATA_W +: DATA_W]    = a;
    reqB[r*DATA_W +: DATA_W]    = b;
    reqCtrl[r*CTRL_W +: CTRL_W] = ctrl;
  endtask

  task automatic resetDut();
    rst      = 1'b1;
    reqValid = '0;
    rspReady = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  // One complete transaction from a single requester, with rsp_ready held high.
  task automatic doOp(input int r, input logic [31:0] a, input logic [31:0] b, input logic [2:0] ctrl,
                      input logic [31:0] expRes, input logic [3:0] expFlags, input string tag);
    applyStimulus(r, a, b, ctrl);
    reqValid    = '0;
    reqValid[r] = 1'b1;
    rspReady    = 1'b1;
    #1;
    checkOutput({tag, ".ready"}, 32'(reqReady), 32'(1 << r));
    tick();
    reqValid = '0;
    checkOutput({tag, ".issueNoValid"}, 32'(rspValid), 32'd0);
    tick();
    checkOutput({tag, ".valid"}, 32'(rspValid), 32'd1);
    checkOutput({tag, ".id"}, 32'(rspId), 32'(r));
    checkOutput({tag, ".result"}, rspResult, expRes);
    checkOutput({tag, ".flags"}, 32'(rspFlags), 32'(expFlags));
    checkOutput({tag, ".err"}, 32'(rspErr), 32'd0);
    tick();
    checkOutput({tag, ".backIdle"}, 32'(rspValid), 32'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset values with a request already pending: ready must stay low.
    reqValid = 2'b01;
    tick();
    checkOutput("rst.ready", 32'(reqReady), 32'd0);
    checkOutput("rst.valid", 32'(rspValid), 32'd0);
    checkOutput("rst.aluA", aluA, 32'd0);
    checkOutput("rst.aluCtrl", 32'(aluCtrl), 32'd0);
    checkOutput("rst.result", rspResult, 32'd0);
    checkOutput("rst.err", 32'(rspErr), 32'd0);
    resetDut();

    // Basic ADD from requester 0.
    doOp(0, 32'd5, 32'd7, OP_ADD, 32'd12, 4'b0000, "add5p7");

    // Both requesters held valid: fresh reset means grants go 0,1,0,1.
    resetDut();
    applyStimulus(0, 32'd10, 32'd20, OP_ADD);
    applyStimulus(1, 32'h0000_00F0, 32'h0000_000F, OP_OR);
    reqValid = 2'b11;
    rspReady = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      checkOutput("rr.ready", 32'(reqReady), 32'(1 << (k % 2)));
      tick();
      tick();
      checkOutput("rr.valid", 32'(rspValid), 32'd1);
      checkOutput("rr.id", 32'(rspId), 32'(k % 2));
      checkOutput("rr.result", rspResult, (k % 2 == 0) ? 32'd30 : 32'h0000_00FF);
      tick();
    end
    reqValid = '0;
    #1;

    // Flag corner cases.
    doOp(0, 32'd3, 32'd3, OP_SUB, 32'd0, 4'b0110, "sub3m3");
    doOp(1, 32'h7FFF_FFFF, 32'd1, OP_ADD, 32'h8000_0000, 4'b1001, "addOvf");
    doOp(0, 32'd2, 32'd5, OP_SLT, 32'd1, 4'b0000, "slt2lt5");
    doOp(1, 32'hFFFF_FFFF, 32'd1, OP_SLT, 32'd1, 4'b0000, "sltNeg");
    doOp(0, 32'd5, 32'd2, OP_SLT, 32'd0, 4'b0100, "slt5lt2");

    // Back-pressure in RESP while requester 1 waits.
    applyStimulus(0, 32'h0000_00FF, 32'h0000_000F, OP_AND);
    applyStimulus(1, 32'd10, 32'd3, OP_SUB);
    reqValid = 2'b01;
    rspReady = 1'b0;
    #1;
    checkOutput("bp.grant0", 32'(reqReady), 32'b01);
    tick();
    reqValid = 2'b10;
    tick();
    for (int k = 0; k < 5; k++) begin
      checkOutput("bp.valid", 32'(rspValid), 32'd1);
      checkOutput("bp.result", rspResult, 32'h0000_000F);
      checkOutput("bp.id", 32'(rspId), 32'd0);
      checkOutput("bp.flags", 32'(rspFlags), 32'd0);
      checkOutput("bp.ready", 32'(reqReady), 32'd0);
      tick();
    end
    rspReady = 1'b1;
    tick();
    checkOutput("bp.grant1", 32'(reqReady), 32'b10);
    tick();
    reqValid = '0;
    tick();
    checkOutput("bp.id1", 32'(rspId), 32'd1);
    checkOutput("bp.result1", rspResult, 32'd7);
    checkOutput("bp.flags1", 32'(rspFlags), 32'b0010);
    tick();

    // Reset in ISSUE: everything clears at once and the op is dropped.
    applyStimulus(0, 32'd4, 32'd4, OP_ADD);
    reqValid = 2'b01;
    #1;
    tick();
    rst = 1'b1;
    #1;
    checkOutput("midRst.ready", 32'(reqReady), 32'd0);
    checkOutput("midRst.valid", 32'(rspValid), 32'd0);
    checkOutput("midRst.aluA", aluA, 32'd0);
    checkOutput("midRst.result", rspResult, 32'd0);
    checkOutput("midRst.id", 32'(rspId), 32'd0);
    checkOutput("midRst.flags", 32'(rspFlags), 32'd0);
    tick();
    tick();
    rst      = 1'b0;
    reqValid = '0;
    tick();
    checkOutput("midRst.noRsp1", 32'(rspValid), 32'd0);
    tick();
    checkOutput("midRst.noRsp2", 32'(rspValid), 32'd0);
    applyStimulus(1, 32'd1, 32'd1, OP_ADD);
    reqValid = 2'b11;
    #1;
    checkOutput("postRst.prio0", 32'(reqReady), 32'b01);
    tick();
    reqValid = '0;
    tick();
    checkOutput("postRst.id", 32'(rspId), 32'd0);
    checkOutput("postRst.result", rspResult, 32'd8);
    tick();

    // Unsupported control code 111; the previous op left ctrl=000 and a=4.
    applyStimulus(0, 32'd1, 32'd2, 3'b111);
    reqValid = 2'b01;
    #1;
    checkOutput("ill.ready", 32'(reqReady), 32'b01);
    tick();
    reqValid = '0;
`ifdef ALU_OPCHK_EN
    checkOutput("ill.aluCtrlKept", 32'(aluCtrl), 32'd0);
    checkOutput("ill.aluAKept", aluA, 32'd4);
    tick();
    checkOutput("ill.valid", 32'(rspValid), 32'd1);
    checkOutput("ill.err", 32'(rspErr), 32'd1);
    checkOutput("ill.result", rspResult, 32'd0);
    checkOutput("ill.flags", 32'(rspFlags), 32'b0100);
`else
    checkOutput("ill.aluCtrlPass", 32'(aluCtrl), 32'd7);
    checkOutput("ill.aluAPass", aluA, 32'd1);
    tick();
    checkOutput("ill.valid", 32'(rspValid), 32'd1);
    checkOutput("ill.err", 32'(rspErr), 32'd0);
`endif
    tick();

    // A legal op afterwards must clear any error indication.
    doOp(0, 32'h0000_FF00, 32'h0000_0FF0, OP_AND, 32'h0000_0F00, 4'b0000, "andAfterIll");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
